// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter for a single tagged memory port, with load-return routing.
// Optional starvation relief for the icache is enabled by defining MEM_ARB_STARVE_EN.
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         proc2Imem_command,
    input  logic [`XLEN-1:0]   proc2Imem_addr,
    input  logic [1:0]         proc2Dmem_command,
    input  logic [`XLEN-1:0]   proc2Dmem_addr,
    input  logic [63:0]        proc2Dmem_data,
    output logic [3:0]         Imem2proc_response,
    output logic [3:0]         Dmem2proc_response,
    output logic [63:0]        Imem2proc_data,
    output logic [63:0]        Dmem2proc_data,
    output logic [3:0]         Imem2proc_tag,
    output logic [3:0]         Dmem2proc_tag,
    output logic [1:0]         proc2mem_command,
    output logic [`XLEN-1:0]   proc2mem_addr,
    output logic [63:0]        proc2mem_data,
    input  logic [3:0]         mem2proc_response,
    input  logic [63:0]        mem2proc_data,
    input  logic [3:0]         mem2proc_tag,
    output logic               grant_d,
    output logic [3:0]         outstanding_count,
    output logic               tag_err
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be 1..15");
    end

    logic        w_i_act;
    logic        w_d_act;
    logic        w_grant_d;
    logic        w_grant_i;

    assign w_i_act = (proc2Imem_command != BUS_NONE);
    assign w_d_act = (proc2Dmem_command != BUS_NONE);

`ifdef MEM_ARB_STARVE_EN
    logic [3:0] r_starve;
    logic       w_force_i;

    assign w_force_i = w_i_act && w_d_act && (r_starve == 4'(STARVE_LIMIT));
    assign w_grant_d = w_d_act && !w_force_i;

    // Counts cycles the icache waits behind the dcache; any grant or idle cycle clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve <= 4'd0;
        end else if (w_i_act && w_grant_d) begin
            if (r_starve < 4'(STARVE_LIMIT))
                r_starve <= r_starve + 4'd1;
        end else begin
            r_starve <= 4'd0;
        end
    end
`else
    assign w_grant_d = w_d_act;
`endif

    assign w_grant_i = w_i_act && !w_grant_d;

    logic [1:0]       w_cmd;
    logic [`XLEN-1:0] w_addr;
    logic [63:0]      w_data;

    always_comb begin
        w_cmd  = BUS_NONE;
        w_addr = '0;
        w_data = '0;
        if (w_grant_d) begin
            w_cmd  = proc2Dmem_command;
            w_addr = proc2Dmem_addr;
            w_data = proc2Dmem_data;
        end else if (w_grant_i) begin
            w_cmd  = proc2Imem_command;
            w_addr = proc2Imem_addr;
        end
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign proc2mem_command   = reset ? w_cmd  : BUS_NONE;
    assign proc2mem_addr      = reset ? w_addr : '0;
    assign proc2mem_data      = reset ? w_data : '0;
    assign grant_d            = reset && w_grant_d;
    assign Dmem2proc_response = (reset && w_grant_d) ? mem2proc_response : 4'd0;
    assign Imem2proc_response = (reset && w_grant_i) ? mem2proc_response : 4'd0;

    assign Imem2proc_data = mem2proc_data;
    assign Dmem2proc_data = mem2proc_data;

    // Owner table: bit 0 is never set, so tag 0 always reads as invalid. Owner 1 = dcache.
    logic [15:0] r_valid;
    logic [15:0] r_owner;
    logic        r_tag_err;
    logic [3:0]  r_count;

    logic [15:0] w_valid_nxt;
    logic [15:0] w_owner_nxt;
    logic [3:0]  w_count_nxt;
    logic        w_ret_hit;
    logic        w_ret_miss;
    logic        w_alloc;

    assign w_ret_hit  = (mem2proc_tag != 4'd0) && r_valid[mem2proc_tag];
    assign w_ret_miss = (mem2proc_tag != 4'd0) && !r_valid[mem2proc_tag];
    assign w_alloc    = (mem2proc_response != 4'd0) && (w_cmd == BUS_LOAD);

    assign Imem2proc_tag = (reset && w_ret_hit && !r_owner[mem2proc_tag]) ? mem2proc_tag : 4'd0;
    assign Dmem2proc_tag = (reset && w_ret_hit &&  r_owner[mem2proc_tag]) ? mem2proc_tag : 4'd0;

    // Return clears first so a same-cycle reallocation of that tag survives the edge.
    always_comb begin
        w_valid_nxt = r_valid;
        w_owner_nxt = r_owner;
        if (w_ret_hit)
            w_valid_nxt[mem2proc_tag] = 1'b0;
        if (w_alloc) begin
            w_valid_nxt[mem2proc_response] = 1'b1;
            w_owner_nxt[mem2proc_response] = w_grant_d;
        end
        w_valid_nxt[0] = 1'b0;
        w_owner_nxt[0] = 1'b0;
    end

    always_comb begin
        w_count_nxt = 4'd0;
        for (int k = 1; k < 16; k++)
            w_count_nxt = w_count_nxt + {3'd0, w_valid_nxt[k]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid   <= '0;
            r_owner   <= '0;
            r_count   <= 4'd0;
            r_tag_err <= 1'b0;
        end else begin
            r_valid   <= w_valid_nxt;
            r_owner   <= w_owner_nxt;
            r_count   <= w_count_nxt;
            r_tag_err <= r_tag_err | w_ret_miss;
        end
    end

    assign outstanding_count = r_count;
    assign tag_err           = r_tag_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; starvation expectations follow MEM_ARB_STARVE_EN.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arbiter;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic               clock = 1'b0;
    logic               reset;
    logic [1:0]         proc2Imem_command;
    logic [`XLEN-1:0]   proc2Imem_addr;
    logic [1:0]         proc2Dmem_command;
    logic [`XLEN-1:0]   proc2Dmem_addr;
    logic [63:0]        proc2Dmem_data;
    logic [3:0]         Imem2proc_response;
    logic [3:0]         Dmem2proc_response;
    logic [63:0]        Imem2proc_data;
    logic [63:0]        Dmem2proc_data;
    logic [3:0]         Imem2proc_tag;
    logic [3:0]         Dmem2proc_tag;
    logic [1:0]         proc2mem_command;
    logic [`XLEN-1:0]   proc2mem_addr;
    logic [63:0]        proc2mem_data;
    logic [3:0]         mem2proc_response;
    logic [63:0]        mem2proc_data;
    logic [3:0]         mem2proc_tag;
    logic               grant_d;
    logic [3:0]         outstanding_count;
    logic               tag_err;

    int n_chk = 0;
    int n_bad = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .proc2Imem_command  (proc2Imem_command),
        .proc2Imem_addr     (proc2Imem_addr),
        .proc2Dmem_command  (proc2Dmem_command),
        .proc2Dmem_addr     (proc2Dmem_addr),
        .proc2Dmem_data     (proc2Dmem_data),
        .Imem2proc_response (Imem2proc_response),
        .Dmem2proc_response (Dmem2proc_response),
        .Imem2proc_data     (Imem2proc_data),
        .Dmem2proc_data     (Dmem2proc_data),
        .Imem2proc_tag      (Imem2proc_tag),
        .Dmem2proc_tag      (Dmem2proc_tag),
        .proc2mem_command   (proc2mem_command),
        .proc2mem_addr      (proc2mem_addr),
        .proc2mem_data      (proc2mem_data),
        .mem2proc_response  (mem2proc_response),
        .mem2proc_data      (mem2proc_data),
        .mem2proc_tag       (mem2proc_tag),
        .grant_d            (grant_d),
        .outstanding_count  (outstanding_count),
        .tag_err            (tag_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        proc2Imem_command = BUS_NONE;
        proc2Imem_addr    = '0;
        proc2Dmem_command = BUS_NONE;
        proc2Dmem_addr    = '0;
        proc2Dmem_data    = '0;
        mem2proc_response = 4'd0;
        mem2proc_data     = '0;
        mem2proc_tag      = 4'd0;
    endtask

    // Inputs change at the falling edge; checks run 1ns later, well before the rising edge.
    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    logic exp_gd;

    initial begin
        reset = 1'b0;
        idle();
        proc2Imem_command = BUS_LOAD;
        proc2Dmem_command = BUS_LOAD;
        proc2Dmem_addr    = 32'h40;
        proc2Dmem_data    = 64'h77;
        mem2proc_response = 4'd2;
        @(negedge clock);
        #1;
        check("rst_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
        check("rst_addr",  64'(proc2mem_addr), 64'd0);
        check("rst_data",  proc2mem_data, 64'd0);
        check("rst_gd",    64'(grant_d), 64'd0);
        check("rst_iresp", 64'(Imem2proc_response), 64'd0);
        check("rst_dresp", 64'(Dmem2proc_response), 64'd0);
        check("rst_cnt",   64'(outstanding_count), 64'd0);
        check("rst_err",   64'(tag_err), 64'd0);

        @(negedge clock);
        reset = 1'b1;
        idle();

        // Icache-only load accepted with tag 3, then returned.
        proc2Imem_command = BUS_LOAD;
        proc2Imem_addr    = 32'h100;
        mem2proc_response = 4'd3;
        #1;
        check("i_cmd",   64'(proc2mem_command), 64'(BUS_LOAD));
        check("i_addr",  64'(proc2mem_addr), 64'h100);
        check("i_data0", proc2mem_data, 64'd0);
        check("i_gd",    64'(grant_d), 64'd0);
        check("i_iresp", 64'(Imem2proc_response), 64'd3);
        check("i_dresp", 64'(Dmem2proc_response), 64'd0);
        next_cycle();
        idle();
        #1;
        check("i_cnt1", 64'(outstanding_count), 64'd1);
        mem2proc_tag  = 4'd3;
        mem2proc_data = 64'hDEADBEEF_00000013;
        #1;
        check("i_itag",  64'(Imem2proc_tag), 64'd3);
        check("i_dtag",  64'(Dmem2proc_tag), 64'd0);
        check("i_idata", Imem2proc_data, 64'hDEADBEEF_00000013);
        check("i_ddata", Dmem2proc_data, 64'hDEADBEEF_00000013);
        next_cycle();
        idle();
        #1;
        check("i_cnt0", 64'(outstanding_count), 64'd0);
        check("i_err0", 64'(tag_err), 64'd0);

        // Both active, dcache store wins and allocates nothing.
        proc2Imem_command = BUS_LOAD;
        proc2Imem_addr    = 32'h300;
        proc2Dmem_command = BUS_STORE;
        proc2Dmem_addr    = 32'h200;
        proc2Dmem_data    = 64'h55;
        mem2proc_response = 4'd5;
        #1;
        check("s_gd",    64'(grant_d), 64'd1);
        check("s_cmd",   64'(proc2mem_command), 64'(BUS_STORE));
        check("s_addr",  64'(proc2mem_addr), 64'h200);
        check("s_data",  proc2mem_data, 64'h55);
        check("s_iresp", 64'(Imem2proc_response), 64'd0);
        check("s_dresp", 64'(Dmem2proc_response), 64'd5);
        next_cycle();
        idle();
        #1;
        check("s_cnt", 64'(outstanding_count), 64'd0);

        // Tag 7: icache owns it, returned while dcache reallocates it.
        proc2Imem_command = BUS_LOAD;
        proc2Imem_addr    = 32'h700;
        mem2proc_response = 4'd7;
        next_cycle();
        idle();
        proc2Dmem_command = BUS_LOAD;
        proc2Dmem_addr    = 32'h780;
        mem2proc_response = 4'd7;
        mem2proc_tag      = 4'd7;
        #1;
        check("r_itag",  64'(Imem2proc_tag), 64'd7);
        check("r_dtag",  64'(Dmem2proc_tag), 64'd0);
        check("r_dresp", 64'(Dmem2proc_response), 64'd7);
        next_cycle();
        idle();
        #1;
        check("r_cnt1", 64'(outstanding_count), 64'd1);
        mem2proc_tag = 4'd7;
        #1;
        check("r_itag2", 64'(Imem2proc_tag), 64'd0);
        check("r_dtag2", 64'(Dmem2proc_tag), 64'd7);
        next_cycle();
        idle();
        #1;
        check("r_cnt0", 64'(outstanding_count), 64'd0);

        // Continuous contention; tag 1 accepted every cycle.
        for (int i = 0; i < 10; i++) begin
            proc2Imem_command = BUS_LOAD;
            proc2Imem_addr    = 32'h900;
            proc2Dmem_command = BUS_LOAD;
            proc2Dmem_addr    = 32'hA00;
            mem2proc_response = 4'd1;
`ifdef MEM_ARB_STARVE_EN
            exp_gd = (i != 4 && i != 9);
`else
            exp_gd = 1'b1;
`endif
            #1;
            check($sformatf("st_gd%0d", i), 64'(grant_d), 64'(exp_gd));
            check($sformatf("st_ir%0d", i), 64'(Imem2proc_response), exp_gd ? 64'd0 : 64'd1);
            next_cycle();
        end
        idle();
        #1;
        check("st_cnt", 64'(outstanding_count), 64'd1);

        // Return of a tag that was never allocated.
        mem2proc_tag = 4'd9;
        #1;
        check("u_itag", 64'(Imem2proc_tag), 64'd0);
        check("u_dtag", 64'(Dmem2proc_tag), 64'd0);
        check("u_err0", 64'(tag_err), 64'd0);
        next_cycle();
        idle();
        #1;
        check("u_err1", 64'(tag_err), 64'd1);
        next_cycle();
        #1;
        check("u_err2", 64'(tag_err), 64'd1);

        // Three icache loads outstanding, then an asynchronous mid-cycle reset.
        for (int i = 0; i < 3; i++) begin
            proc2Imem_command = BUS_LOAD;
            proc2Imem_addr    = 32'h1000 + 32'(i);
            mem2proc_response = 4'(2 * i + 2);
            next_cycle();
        end
        #1;
        check("m_cnt4", 64'(outstanding_count), 64'd4);
        proc2Dmem_command = BUS_LOAD;
        proc2Dmem_addr    = 32'h2000;
        mem2proc_response = 4'd8;
        #1;
        reset = 1'b0;
        #1;
        check("m_cnt0",  64'(outstanding_count), 64'd0);
        check("m_err0",  64'(tag_err), 64'd0);
        check("m_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
        check("m_gd",    64'(grant_d), 64'd0);
        check("m_iresp", 64'(Imem2proc_response), 64'd0);
        check("m_dresp", 64'(Dmem2proc_response), 64'd0);
        next_cycle();
        reset = 1'b1;
        idle();
        mem2proc_tag = 4'd2;
        #1;
        check("m_itag", 64'(Imem2proc_tag), 64'd0);
        next_cycle();
        idle();
        #1;
        check("m_err1", 64'(tag_err), 64'd1);
        check("m_cntf", 64'(outstanding_count), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
